reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 197 +++++++++++++++++++
 tb/tb_reservation_station.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds issued ops until both operands are available,
// wakes them up from ALU/LSB broadcasts and dispatches one ready op per cycle.
module reservation_station #(
  parameter int RS_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        issue_valid,
  input  logic [6:0]  issue_opcode,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_vj,
  input  logic [31:0] issue_vk,
  input  logic        issue_qj_busy,
  input  logic        issue_qk_busy,
  input  logic [4:0]  issue_qj,
  input  logic [4:0]  issue_qk,
  input  logic [4:0]  issue_dest,
  input  logic        alu_valid,
  input  logic [4:0]  alu_name,
  input  logic [31:0] alu_value,
  input  logic        lsb_valid,
  input  logic [4:0]  lsb_name,
  input  logic [31:0] lsb_value,
  output logic        rs_full,
  output logic [6:0]  exe_opcode,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_rs1,
  output logic [31:0] exe_rs2,
  output logic [31:0] exe_imm,
  output logic [4:0]  exe_calc_name
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [6:0]         opcode [RS_SIZE];
  logic [31:0]        pc     [RS_SIZE];
  logic [31:0]        imm    [RS_SIZE];
  logic [31:0]        vj     [RS_SIZE];
  logic [31:0]        vk     [RS_SIZE];
  logic [4:0]         qj     [RS_SIZE];
  logic [4:0]         qk     [RS_SIZE];
  logic [4:0]         dest   [RS_SIZE];

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          ready_found;
  logic [IW-1:0] ready_idx;
  logic          issue_ok;

  logic [31:0]   new_vj;
  logic [31:0]   new_vk;
  logic          new_qj_busy;
  logic          new_qk_busy;

  assign rs_full  = &busy;
  assign issue_ok = issue_valid && !rs_full;

  // Lowest-index free slot; descending scan lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Lowest-index entry whose registered operands are both available.
  always_comb begin
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
        ready_found = 1'b1;
        ready_idx   = IW'(i);
      end
    end
  end

  // Same-cycle bypass of broadcasts into the operands being issued.
  always_comb begin
    new_vj      = issue_vj;
    new_qj_busy = issue_qj_busy;
    new_vk      = issue_vk;
    new_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (alu_valid && alu_name == issue_qj) begin
        new_vj      = alu_value;
        new_qj_busy = 1'b0;
      end else if (lsb_valid && lsb_name == issue_qj) begin
        new_vj      = lsb_value;
        new_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (alu_valid && alu_name == issue_qk) begin
        new_vk      = alu_value;
        new_qk_busy = 1'b0;
      end else if (lsb_valid && lsb_name == issue_qk) begin
        new_vk      = lsb_value;
        new_qk_busy = 1'b0;
      end
    end
  end

  // Entry state: flush clears, otherwise wakeup, dispatch release and issue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy    <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opcode[i] <= '0;
        pc[i]     <= '0;
        imm[i]    <= '0;
        vj[i]     <= '0;
        vk[i]     <= '0;
        qj[i]     <= '0;
        qk[i]     <= '0;
        dest[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_valid && alu_name == qj[i]) begin
              vj[i]      <= alu_value;
              qj_busy[i] <= 1'b0;
            end else if (lsb_valid && lsb_name == qj[i]) begin
              vj[i]      <= lsb_value;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_valid && alu_name == qk[i]) begin
              vk[i]      <= alu_value;
              qk_busy[i] <= 1'b0;
            end else if (lsb_valid && lsb_name == qk[i]) begin
              vk[i]      <= lsb_value;
              qk_busy[i] <= 1'b0;
            end
          end
        end
        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
        end
        if (issue_ok && free_found) begin
          busy[free_idx]    <= 1'b1;
          opcode[free_idx]  <= issue_opcode;
          pc[free_idx]      <= issue_pc;
          imm[free_idx]     <= issue_imm;
          vj[free_idx]      <= new_vj;
          vk[free_idx]      <= new_vk;
          qj_busy[free_idx] <= new_qj_busy;
          qk_busy[free_idx] <= new_qk_busy;
          qj[free_idx]      <= issue_qj;
          qk[free_idx]      <= issue_qk;
          dest[free_idx]    <= issue_dest;
        end
      end
    end
  end

  // Dispatch register: opcode 0 marks an idle cycle, payload holds.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      exe_opcode    <= '0;
      exe_pc        <= '0;
      exe_rs1       <= '0;
      exe_rs2       <= '0;
      exe_imm       <= '0;
      exe_calc_name <= '0;
    end else if (rdy_in) begin
      if (flush_in || !ready_found) begin
        exe_opcode <= '0;
      end else begin
        exe_opcode    <= opcode[ready_idx];
        exe_pc        <= pc[ready_idx];
        exe_rs1       <= vj[ready_idx];
        exe_rs2       <= vk[ready_idx];
        exe_imm       <= imm[ready_idx];
        exe_calc_name <= dest[ready_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table of single ops
// followed by hand sequences for full, flush, stall, wakeup and reset.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        issue_valid;
  logic [6:0]  issue_opcode;
  logic [31:0] issue_pc;
  logic [31:0] issue_imm;
  logic [31:0] issue_vj;
  logic [31:0] issue_vk;
  logic        issue_qj_busy;
  logic        issue_qk_busy;
  logic [4:0]  issue_qj;
  logic [4:0]  issue_qk;
  logic [4:0]  issue_dest;
  logic        alu_valid;
  logic [4:0]  alu_name;
  logic [31:0] alu_value;
  logic        lsb_valid;
  logic [4:0]  lsb_name;
  logic [31:0] lsb_value;
  logic        rs_full;
  logic [6:0]  exe_opcode;
  logic [31:0] exe_pc;
  logic [31:0] exe_rs1;
  logic [31:0] exe_rs2;
  logic [31:0] exe_imm;
  logic [4:0]  exe_calc_name;

  int checks = 0;
  int errors = 0;

  reservation_station #(.RS_SIZE(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .issue_valid   (issue_valid),
    .issue_opcode  (issue_opcode),
    .issue_pc      (issue_pc),
    .issue_imm     (issue_imm),
    .issue_vj      (issue_vj),
    .issue_vk      (issue_vk),
    .issue_qj_busy (issue_qj_busy),
    .issue_qk_busy (issue_qk_busy),
    .issue_qj      (issue_qj),
    .issue_qk      (issue_qk),
    .issue_dest    (issue_dest),
    .alu_valid     (alu_valid),
    .alu_name      (alu_name),
    .alu_value     (alu_value),
    .lsb_valid     (lsb_valid),
    .lsb_name      (lsb_name),
    .lsb_value     (lsb_value),
    .rs_full       (rs_full),
    .exe_opcode    (exe_opcode),
    .exe_pc        (exe_pc),
    .exe_rs1       (exe_rs1),
    .exe_rs2       (exe_rs2),
    .exe_imm       (exe_imm),
    .exe_calc_name (exe_calc_name)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qjb;
    logic [4:0]  qj;
    logic        qkb;
    logic [4:0]  qk;
    logic [4:0]  dest;
    logic        av;
    logic [4:0]  an;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  ln;
    logic [31:0] lval;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear();
    flush_in      = 1'b0;
    issue_valid   = 1'b0;
    issue_opcode  = '0;
    issue_pc      = '0;
    issue_imm     = '0;
    issue_vj      = '0;
    issue_vk      = '0;
    issue_qj_busy = 1'b0;
    issue_qk_busy = 1'b0;
    issue_qj      = '0;
    issue_qk      = '0;
    issue_dest    = '0;
    alu_valid     = 1'b0;
    alu_name      = '0;
    alu_value     = '0;
    lsb_valid     = 1'b0;
    lsb_name      = '0;
    lsb_value     = '0;
  endtask

  task automatic iss(input logic [6:0] op, input logic [31:0] pc,
                     input logic [31:0] vj, input logic [31:0] vk,
                     input logic qjb, input logic [4:0] qj,
                     input logic qkb, input logic [4:0] qk,
                     input logic [4:0] dest);
    issue_valid   = 1'b1;
    issue_opcode  = op;
    issue_pc      = pc;
    issue_imm     = 32'h0000_0004;
    issue_vj      = vj;
    issue_vk      = vk;
    issue_qj_busy = qjb;
    issue_qj      = qj;
    issue_qk_busy = qkb;
    issue_qk      = qk;
    issue_dest    = dest;
  endtask

  task automatic bcast(input logic av, input logic [4:0] an,
                       input logic [31:0] aval, input logic lv,
                       input logic [4:0] ln, input logic [31:0] lval);
    alu_valid = av;
    alu_name  = an;
    alu_value = aval;
    lsb_valid = lv;
    lsb_name  = ln;
    lsb_value = lval;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{7'h01, 32'h100, 32'h0, 32'd5, 32'd7,
              1'b0, 5'd0, 1'b0, 5'd0, 5'd3,
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              32'd5, 32'd7};
    vt[1] = '{7'h22, 32'h104, 32'hFFF, 32'hDEAD_BEEF, 32'h0,
              1'b0, 5'd0, 1'b1, 5'd9, 5'd4,
              1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hFF,
              32'hDEAD_BEEF, 32'hFF};
    vt[2] = '{7'h33, 32'h108, 32'h10, 32'h0, 32'h55,
              1'b1, 5'd0, 1'b0, 5'd0, 5'd0,
              1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0,
              32'h1234, 32'h55};
    vt[3] = '{7'h44, 32'h10C, 32'h20, 32'h0, 32'h0,
              1'b1, 5'd7, 1'b1, 5'd8, 5'd12,
              1'b1, 5'd8, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB,
              32'hBBBB, 32'hAAAA};
    vt[4] = '{7'h55, 32'h110, 32'h30, 32'h0, 32'h9,
              1'b1, 5'd31, 1'b0, 5'd0, 5'd30,
              1'b1, 5'd31, 32'h8000_0000, 1'b1, 5'd30, 32'h1,
              32'h8000_0000, 32'h9};
    vt[5] = '{7'h7F, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h66, 32'h77,
              1'b0, 5'd2, 1'b0, 5'd0, 5'd31,
              1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'h0,
              32'h66, 32'h77};

    clear();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    #1;
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_op", 32'(exe_opcode), 32'd0);
    iss(7'h01, 32'h1, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    tick();
    tick();
    chk("rst_op_clk", 32'(exe_opcode), 32'd0);
    chk("rst_pc", exe_pc, 32'd0);
    chk("rst_name", 32'(exe_calc_name), 32'd0);
    clear();
    rst_in = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      issue_valid   = 1'b1;
      issue_opcode  = vt[v].op;
      issue_pc      = vt[v].pc;
      issue_imm     = vt[v].imm;
      issue_vj      = vt[v].vj;
      issue_vk      = vt[v].vk;
      issue_qj_busy = vt[v].qjb;
      issue_qj      = vt[v].qj;
      issue_qk_busy = vt[v].qkb;
      issue_qk      = vt[v].qk;
      issue_dest    = vt[v].dest;
      bcast(vt[v].av, vt[v].an, vt[v].aval, vt[v].lv, vt[v].ln, vt[v].lval);
      tick();
      clear();
      chk($sformatf("v%0d_lat", v), 32'(exe_opcode), 32'd0);
      tick();
      chk($sformatf("v%0d_op", v), 32'(exe_opcode), 32'(vt[v].op));
      chk($sformatf("v%0d_pc", v), exe_pc, vt[v].pc);
      chk($sformatf("v%0d_rs1", v), exe_rs1, vt[v].e_rs1);
      chk($sformatf("v%0d_rs2", v), exe_rs2, vt[v].e_rs2);
      chk($sformatf("v%0d_imm", v), exe_imm, vt[v].imm);
      chk($sformatf("v%0d_name", v), 32'(exe_calc_name), 32'(vt[v].dest));
      tick();
      chk($sformatf("v%0d_idle", v), 32'(exe_opcode), 32'd0);
      chk($sformatf("v%0d_hold", v), exe_pc, vt[v].pc);
    end

    // wakeup by ALU two cycles after issue
    iss(7'h11, 32'h200, 32'h0, 32'd2, 1'b1, 5'd4, 1'b0, 5'd0, 5'd6);
    tick();
    clear();
    tick();
    chk("wk_wait", 32'(exe_opcode), 32'd0);
    bcast(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'h0);
    tick();
    clear();
    chk("wk_cap", 32'(exe_opcode), 32'd0);
    tick();
    chk("wk_op", 32'(exe_opcode), 32'h11);
    chk("wk_rs1", exe_rs1, 32'h10);
    chk("wk_rs2", exe_rs2, 32'd2);

    // alu and lsb wake different operands of one entry together
    iss(7'h12, 32'h210, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6, 5'd7);
    tick();
    clear();
    bcast(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'h5A);
    tick();
    clear();
    tick();
    chk("dual_op", 32'(exe_opcode), 32'h12);
    chk("dual_rs1", exe_rs1, 32'hA5);
    chk("dual_rs2", exe_rs2, 32'h5A);

    // all five tag bits must match
    iss(7'h13, 32'h220, 32'h0, 32'h3, 1'b1, 5'd1, 1'b0, 5'd0, 5'd8);
    tick();
    clear();
    bcast(1'b1, 5'h11, 32'hEE, 1'b1, 5'h09, 32'hDD);
    tick();
    clear();
    tick();
    chk("tag_miss", 32'(exe_opcode), 32'd0);
    bcast(1'b1, 5'd1, 32'h77, 1'b0, 5'd0, 32'h0);
    tick();
    clear();
    tick();
    chk("tag_hit_op", 32'(exe_opcode), 32'h13);
    chk("tag_hit_rs1", exe_rs1, 32'h77);

    // fill all eight, ninth dropped, release one
    for (int i = 0; i < 8; i++) begin
      iss(7'(8'h20 + i), 32'(32'h300 + i), 32'h0, 32'(i),
          1'b1, 5'(10 + i), 1'b0, 5'd0, 5'(i));
      tick();
    end
    clear();
    chk("full_set", 32'(rs_full), 32'd1);
    iss(7'h40, 32'h400, 32'h1, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
    tick();
    clear();
    chk("full_drop_op", 32'(exe_opcode), 32'd0);
    chk("full_still", 32'(rs_full), 32'd1);
    bcast(1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 32'h0);
    tick();
    clear();
    chk("full_cap", 32'(rs_full), 32'd1);
    tick();
    chk("full_rel_op", 32'(exe_opcode), 32'h22);
    chk("full_rel_rs1", exe_rs1, 32'h99);
    chk("full_rel_rs2", exe_rs2, 32'd2);
    chk("full_clr", 32'(rs_full), 32'd0);
    tick();
    chk("full_ninth", 32'(exe_opcode), 32'd0);
    flush_in = 1'b1;
    tick();
    clear();
    chk("flush_empty", 32'(rs_full), 32'd0);

    // flush overrides issue and a pending dispatch
    for (int i = 0; i < 3; i++) begin
      iss(7'(8'h50 + i), 32'h500, 32'h0, 32'h0,
          1'b1, 5'(20 + i), 1'b0, 5'd0, 5'(i));
      tick();
    end
    iss(7'h56, 32'h560, 32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    tick();
    clear();
    flush_in = 1'b1;
    iss(7'h57, 32'h570, 32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    tick();
    clear();
    chk("fl_op", 32'(exe_opcode), 32'd0);
    tick();
    chk("fl_drop", 32'(exe_opcode), 32'd0);
    bcast(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    tick();
    clear();
    tick();
    chk("fl_gone", 32'(exe_opcode), 32'd0);

    // back-to-back issue while dispatching
    iss(7'h61, 32'h610, 32'd1, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    tick();
    iss(7'h62, 32'h620, 32'd2, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2);
    tick();
    clear();
    chk("b2b_a_op", 32'(exe_opcode), 32'h61);
    chk("b2b_a_rs1", exe_rs1, 32'd1);
    tick();
    chk("b2b_b_op", 32'(exe_opcode), 32'h62);
    chk("b2b_b_rs1", exe_rs1, 32'd2);
    tick();

    // asynchronous reset mid-operation
    iss(7'h6E, 32'h6E0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd1);
    tick();
    iss(7'h70, 32'h700, 32'h5, 32'h6, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2);
    tick();
    clear();
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_full", 32'(rs_full), 32'd0);
    chk("ar_pc", exe_pc, 32'd0);
    chk("ar_rs1", exe_rs1, 32'd0);
    @(posedge clk_in);
    #1;
    chk("ar_op", 32'(exe_opcode), 32'd0);
    rst_in = 1'b0;
    bcast(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0);
    tick();
    clear();
    tick();
    chk("ar_gone", 32'(exe_opcode), 32'd0);
    iss(7'h71, 32'h710, 32'h8, 32'h9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    tick();
    clear();
    tick();
    chk("ar_new_op", 32'(exe_opcode), 32'h71);
    chk("ar_new_pc", exe_pc, 32'h710);
    tick();

    // stall with rdy_in low for three cycles
    iss(7'h2A, 32'h2A0, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
    tick();
    clear();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_op", i), 32'(exe_opcode), 32'd0);
      chk($sformatf("stall%0d_pc", i), exe_pc, 32'h710);
    end
    rdy_in = 1'b1;
    tick();
    chk("stall_op", 32'(exe_opcode), 32'h2A);
    chk("stall_rs1", exe_rs1, 32'h11);
    chk("stall_rs2", exe_rs2, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
